// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical memory port between the I-cache and D-cache.
module cache_arbiter #(
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_pmem_read,
  input  logic [15:0]           i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [15:0]           d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [15:0]           pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;
  state_e                state_q, state_d;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [15:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic                  d_req, starved, grant_i, grant_d;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign starved = starve_cnt_q == SW'(STARVE_LIMIT);
  assign grant_i = (state_q == IDLE) & i_pmem_read & (~d_req | starved);
  assign grant_d = (state_q == IDLE) & d_req & ~grant_i;
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = pmem_resp & (state_q == I_BUSY);
  assign d_pmem_resp  = pmem_resp & (state_q == D_BUSY);
  // Grant arbitration, request latching, and return to IDLE on memory response
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    if (grant_i) begin
      state_d      = I_BUSY;
      starve_cnt_d = '0;
      addr_d       = i_pmem_address;
      rd_d         = 1'b1;
      wr_d         = 1'b0;
    end else if (grant_d) begin
      state_d      = D_BUSY;
      starve_cnt_d = (i_pmem_read && !starved) ? starve_cnt_q + 1'b1 : starve_cnt_q;
      addr_d       = d_pmem_address;
      wr_d         = d_pmem_write;
      rd_d         = ~d_pmem_write;
      wdata_d      = d_pmem_write ? d_pmem_wdata : wdata_q;
    end else if (state_q != IDLE && pmem_resp) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end
  end
  // State and transaction registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and random transaction checks against a grant-order model.
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_pmem_read, d_pmem_read, d_pmem_write, pmem_resp;
  logic [15:0]  i_pmem_address, d_pmem_address;
  logic [127:0] d_pmem_wdata, pmem_rdata;
  logic [127:0] i_pmem_rdata, d_pmem_rdata, pmem_wdata;
  logic         i_pmem_resp, d_pmem_resp, pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  int           passed = 0, total = 0;
  bit           i_pend, d_pend, d_wr;
  logic [15:0]  i_addr, d_addr;
  logic [127:0] d_data;
  int           starve;

  cache_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_i(input logic [15:0] a);
    i_pend = 1; i_addr = a;
    i_pmem_read = 1; i_pmem_address = a;
  endtask

  task automatic set_d(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] w);
    d_pend = 1; d_wr = wr; d_addr = a; d_data = w;
    d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = w;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called in an IDLE cycle (posedge+1) with requests driven; runs one full transaction.
  task automatic serve(input int lat, input logic [127:0] rdat);
    bit ed, ewr;
    logic [15:0] ea;
    ed  = d_pend && !(i_pend && starve == 4);
    ewr = ed && d_wr;
    ea  = ed ? d_addr : i_addr;
    if (ed) starve = i_pend ? ((starve < 4) ? starve + 1 : 4) : starve;
    else starve = 0;
    @(posedge clk); #1;
    chk("grant_rd", pmem_read, !ewr);
    chk("grant_wr", pmem_write, ewr);
    chk("grant_addr", pmem_address, ea);
    if (ewr) chk("grant_wdata", pmem_wdata, d_data);
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); #1;
      chk("hold_addr", pmem_address, ea);
      chk("hold_strobes", {pmem_read, pmem_write}, {!ewr, ewr});
      chk("hold_noresp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    end
    pmem_resp = 1; pmem_rdata = rdat; #1;
    chk("resp_i", i_pmem_resp, !ed);
    chk("resp_d", d_pmem_resp, ed);
    chk("rdata_i", i_pmem_rdata, rdat);
    chk("rdata_d", d_pmem_rdata, rdat);
    chk("resp_strobe", {pmem_read, pmem_write}, {!ewr, ewr});
    @(posedge clk); #1;
    pmem_resp = 0;
    chk("gap_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("gap_noresp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    if (ed) begin d_pend = 0; d_pmem_read = 0; d_pmem_write = 0; end
    else begin i_pend = 0; i_pmem_read = 0; end
  endtask

  initial begin
    reset_n = 0; pmem_resp = 0; pmem_rdata = '0;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    i_pend = 0; d_pend = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_data = '0; starve = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_address, 16'h0000);
    chk("rst_wdata", pmem_wdata, 128'h0);
    chk("rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    // I-only fill, granted on the first edge after reset release
    set_i(16'h0120);
    reset_n = 1;
    serve(5, {16{8'hA5}});
    // Stray response in IDLE is ignored
    pmem_resp = 1; #1;
    chk("stray_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1;
    pmem_resp = 0;
    chk("stray_idle", {pmem_read, pmem_write}, 2'b00);
    // Simultaneous requests: D first, gap, then I
    set_i(16'h0200);
    set_d(1, 0, 16'h0300, '0);
    serve(2, rnd128());
    chk("simul_i_waiting", i_pend, 1'b1);
    serve(3, rnd128());
    // D writeback, then read+write together resolves as write
    set_d(0, 1, 16'h0340, {8{16'h1234}});
    serve(3, rnd128());
    set_d(1, 1, 16'h0344, rnd128());
    serve(1, rnd128());
    // Starvation: I waits while D re-requests every IDLE cycle
    set_i(16'h0500);
    for (int n = 0; n < 4; n++) begin
      set_d(1, 0, 16'h0600 + 16'(n), '0);
      serve(2, rnd128());
    end
    chk("starve_i_pending", i_pend, 1'b1);
    set_d(1, 0, 16'h0610, '0);
    serve(2, rnd128());
    chk("starve_i_served", i_pend, 1'b0);
    chk("starve_cnt_clear", dut.starve_cnt_q, 0);
    serve(2, rnd128());
    // Reset during I_BUSY abandons the transaction
    set_i(16'h0777);
    @(posedge clk); #1;
    chk("mr_started", pmem_read, 1'b1);
    @(posedge clk); #1;
    reset_n = 0; #1;
    chk("mr_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("mr_addr", pmem_address, 16'h0000);
    pmem_resp = 1; #1;
    chk("mr_noresp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    pmem_resp = 0;
    starve = 0;
    @(posedge clk); #1;
    reset_n = 1;
    serve(2, rnd128());
    // Random traffic
    for (int it = 0; it < 40; it++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) set_i(16'($urandom));
      if (!d_pend && ($urandom_range(0, 1) == 1 || !i_pend)) begin
        int r;
        r = $urandom_range(1, 3);
        set_d(r[0], r[1], 16'($urandom), rnd128());
      end
      serve($urandom_range(1, 6), rnd128());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
